// File: rtl/rf_sb_pkg.sv
// Shared constants for the register-file scoreboard: register-number and data widths,
// default register count and long-unit credit limit.
package rf_sb_pkg;
    localparam int NREG_DEF   = 32;
    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int LU_MAX_DEF = 2;
    localparam int LU_CNT_W   = 2;
endpackage

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: pipeline writeback always beats the long unit,
// and the granted source drives the write port.
module rf_wb_arb
    import rf_sb_pkg::*;
(
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_wn,
    input  logic [DATA_W-1:0] wb_d,
    input  logic              lu_valid,
    input  logic [REG_W-1:0]  lu_wn,
    input  logic [DATA_W-1:0] lu_d,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wn,
    output logic [DATA_W-1:0] rf_d
);

    always_comb begin
        lu_ready = lu_valid && !wb_valid;
        rf_wn    = '0;
        rf_d     = '0;
        if (wb_valid) begin
            rf_wn = wb_wn;
            rf_d  = wb_d;
        end else if (lu_valid) begin
            rf_wn = lu_wn;
            rf_d  = lu_d;
        end
        // register 0 writes are still granted so the source drains, but never reach the file
        rf_we = (wb_valid || lu_valid) && (rf_wn != '0);
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Issue scoreboard: tracks registers with an in-flight write, blocks hazardous issue,
// and counts outstanding long-unit results.
module rf_scoreboard
    import rf_sb_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int LU_MAX = LU_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid,
    input  logic [REG_W-1:0]    iss_rs,
    input  logic [REG_W-1:0]    iss_rt,
    input  logic                iss_use_rt,
    input  logic                iss_wen,
    input  logic [REG_W-1:0]    iss_wn,
    input  logic                iss_long,
    output logic                iss_ready,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_wn,
    input  logic [DATA_W-1:0]   wb_d,
    input  logic                lu_valid,
    input  logic [REG_W-1:0]    lu_wn,
    input  logic [DATA_W-1:0]   lu_d,
    output logic                lu_ready,
    output logic                rf_we,
    output logic [REG_W-1:0]    rf_wn,
    output logic [DATA_W-1:0]   rf_d,
    output logic [LU_CNT_W-1:0] lu_cnt,
    output logic                err
);

    localparam logic [LU_CNT_W-1:0] LU_MAX_C = LU_CNT_W'(LU_MAX);

    logic [NREG-1:0]     pend_q, pend_d, clr, busy;
    logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic                err_q, err_d;
    logic                iss_acc, lu_inc, lu_dec, lu_full;

    rf_wb_arb u_arb (
        .wb_valid (wb_valid),
        .wb_wn    (wb_wn),
        .wb_d     (wb_d),
        .lu_valid (lu_valid),
        .lu_wn    (lu_wn),
        .lu_d     (lu_d),
        .lu_ready (lu_ready),
        .rf_we    (rf_we),
        .rf_wn    (rf_wn),
        .rf_d     (rf_d)
    );

    // The file is written at negedge, so a register written this cycle can already be read.
    always_comb begin
        clr = '0;
        if (rf_we) clr[rf_wn] = 1'b1;
        busy    = pend_q & ~clr;
        busy[0] = 1'b0;
    end

    assign lu_full   = (lu_cnt_q == LU_MAX_C);
    assign iss_ready = !(busy[iss_rs]
                         || (iss_use_rt && busy[iss_rt])
                         || (iss_wen && busy[iss_wn])
                         || (iss_long && iss_wen && lu_full));
    assign iss_acc   = iss_valid && iss_ready;
    assign lu_inc    = iss_acc && iss_long && iss_wen;
    assign lu_dec    = lu_ready;

    always_comb begin
        pend_d   = pend_q & ~clr;
        lu_cnt_d = lu_cnt_q;
        err_d    = err_q;
        if (iss_acc && iss_wen && (iss_wn != '0)) pend_d[iss_wn] = 1'b1;
        pend_d[0] = 1'b0;
        if (rf_we && !pend_q[rf_wn]) err_d = 1'b1;
        if (lu_dec && (lu_cnt_q == '0)) err_d = 1'b1;
        if (lu_inc && !lu_dec) begin
            if (lu_full) err_d = 1'b1;
            else         lu_cnt_d = lu_cnt_q + 1'b1;
        end else if (lu_dec && !lu_inc) begin
            if (lu_cnt_q != '0) lu_cnt_d = lu_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            lu_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            lu_cnt_q <= lu_cnt_d;
            err_q    <= err_d;
        end
    end

    assign lu_cnt = lu_cnt_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: one task per scenario, inline checks against hand-computed values.
module tb_rf_scoreboard;

    logic        clk, rst_n;
    logic        iss_valid, iss_use_rt, iss_wen, iss_long, iss_ready;
    logic [4:0]  iss_rs, iss_rt, iss_wn;
    logic        wb_valid, lu_valid, lu_ready, rf_we, err;
    logic [4:0]  wb_wn, lu_wn, rf_wn;
    logic [31:0] wb_d, lu_d, rf_d;
    logic [1:0]  lu_cnt;

    int passed = 0;
    int total  = 0;

    rf_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_rt(iss_use_rt),
        .iss_wen(iss_wen), .iss_wn(iss_wn), .iss_long(iss_long), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_wn(wb_wn), .wb_d(wb_d),
        .lu_valid(lu_valid), .lu_wn(lu_wn), .lu_d(lu_d), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .lu_cnt(lu_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_use_rt = 0;
        iss_wen = 0; iss_wn = 0; iss_long = 0;
        wb_valid = 0; wb_wn = 0; wb_d = 0;
        lu_valid = 0; lu_wn = 0; lu_d = 0;
    endtask

    // Inputs change 1ns after posedge; checks follow 2ns later, well before the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] wn, input logic lng);
        next_cycle();
        iss_valid = 1; iss_wen = 1; iss_wn = wn; iss_long = lng;
        #2;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #3;
        total++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready: got %b exp 1", iss_ready); else passed++;
        total++; if (lu_ready !== 1'b0) $display("FAIL reset_lu_ready: got %b exp 0", lu_ready); else passed++;
        total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b exp 0", rf_we); else passed++;
        total++; if (rf_wn !== 5'd0 || rf_d !== 32'd0) $display("FAIL reset_rf_port: got wn=%0d d=%h exp 0/0", rf_wn, rf_d); else passed++;
        total++; if (lu_cnt !== 2'd0 || err !== 1'b0) $display("FAIL reset_state: got cnt=%0d err=%b exp 0/0", lu_cnt, err); else passed++;
        #19 rst_n = 1;
    endtask

    task automatic test_raw();
        issue(5'd5, 1'b0);
        total++; if (iss_ready !== 1'b1) $display("FAIL raw_first_issue: got %b exp 1", iss_ready); else passed++;
        next_cycle();
        iss_valid = 1; iss_rs = 5; #2;
        total++; if (iss_ready !== 1'b0) $display("FAIL raw_stall: got %b exp 0", iss_ready); else passed++;
        next_cycle();
        iss_valid = 1; iss_rs = 5; wb_valid = 1; wb_wn = 5; wb_d = 32'hA5; #2;
        total++; if (iss_ready !== 1'b1) $display("FAIL raw_bypass_ready: got %b exp 1", iss_ready); else passed++;
        total++; if (rf_we !== 1'b1 || rf_wn !== 5'd5 || rf_d !== 32'hA5) $display("FAIL raw_wb_port: got we=%b wn=%0d d=%h exp 1/5/a5", rf_we, rf_wn, rf_d); else passed++;
        // WAW and rt checks on a second register
        issue(5'd8, 1'b0);
        total++; if (iss_ready !== 1'b1) $display("FAIL waw_first_issue: got %b exp 1", iss_ready); else passed++;
        next_cycle();
        iss_valid = 1; iss_wen = 1; iss_wn = 8; #2;
        total++; if (iss_ready !== 1'b0) $display("FAIL waw_stall: got %b exp 0", iss_ready); else passed++;
        iss_wen = 0; iss_use_rt = 1; iss_rt = 8; #1;
        total++; if (iss_ready !== 1'b0) $display("FAIL rt_stall: got %b exp 0", iss_ready); else passed++;
        iss_use_rt = 0; #1;
        total++; if (iss_ready !== 1'b1) $display("FAIL rt_unused: got %b exp 1", iss_ready); else passed++;
        next_cycle();
        wb_valid = 1; wb_wn = 8; wb_d = 32'h8; #2;
        next_cycle();
        iss_valid = 1; iss_rs = 8; iss_use_rt = 1; iss_rt = 5; #2;
        total++; if (iss_ready !== 1'b1 || err !== 1'b0) $display("FAIL raw_cleared: got ready=%b err=%b exp 1/0", iss_ready, err); else passed++;
    endtask

    task automatic test_arb();
        issue(5'd3, 1'b0);
        issue(5'd4, 1'b1);
        next_cycle();
        wb_valid = 1; wb_wn = 3; wb_d = 32'h33; lu_valid = 1; lu_wn = 4; lu_d = 32'h44; #2;
        total++; if (rf_wn !== 5'd3 || rf_d !== 32'h33 || lu_ready !== 1'b0) $display("FAIL arb_wb_wins: got wn=%0d d=%h lu_ready=%b exp 3/33/0", rf_wn, rf_d, lu_ready); else passed++;
        total++; if (lu_cnt !== 2'd1) $display("FAIL arb_cnt_before: got %0d exp 1", lu_cnt); else passed++;
        next_cycle();
        lu_valid = 1; lu_wn = 4; lu_d = 32'h44; #2;
        total++; if (rf_wn !== 5'd4 || rf_d !== 32'h44 || lu_ready !== 1'b1 || rf_we !== 1'b1) $display("FAIL arb_lu_grant: got wn=%0d d=%h lu_ready=%b we=%b exp 4/44/1/1", rf_wn, rf_d, lu_ready, rf_we); else passed++;
        next_cycle(); #2;
        total++; if (lu_cnt !== 2'd0 || err !== 1'b0) $display("FAIL arb_cnt_after: got cnt=%0d err=%b exp 0/0", lu_cnt, err); else passed++;
    endtask

    task automatic test_lu_full();
        issue(5'd6, 1'b1);
        issue(5'd7, 1'b1);
        next_cycle(); #2;
        total++; if (lu_cnt !== 2'd2) $display("FAIL full_cnt: got %0d exp 2", lu_cnt); else passed++;
        next_cycle();
        iss_valid = 1; iss_wen = 1; iss_wn = 10; iss_long = 1; lu_valid = 1; lu_wn = 6; lu_d = 32'h6; #2;
        total++; if (iss_ready !== 1'b0 || lu_ready !== 1'b1) $display("FAIL full_no_credit: got ready=%b lu_ready=%b exp 0/1", iss_ready, lu_ready); else passed++;
        next_cycle();
        iss_valid = 1; iss_wen = 1; iss_wn = 10; iss_long = 1; #2;
        total++; if (iss_ready !== 1'b1 || lu_cnt !== 2'd1) $display("FAIL full_released: got ready=%b cnt=%0d exp 1/1", iss_ready, lu_cnt); else passed++;
        next_cycle();
        lu_valid = 1; lu_wn = 7; lu_d = 32'h7; #2;
        total++; if (lu_cnt !== 2'd2) $display("FAIL full_refill: got %0d exp 2", lu_cnt); else passed++;
        next_cycle();
        lu_valid = 1; lu_wn = 10; lu_d = 32'hA; #2;
        next_cycle(); #2;
        total++; if (lu_cnt !== 2'd0 || err !== 1'b0) $display("FAIL full_drain: got cnt=%0d err=%b exp 0/0", lu_cnt, err); else passed++;
    endtask

    task automatic test_reg0();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            iss_valid = 1; iss_wen = 1; iss_wn = 0; iss_rs = 0; iss_use_rt = 1; iss_rt = 0; #2;
            total++; if (iss_ready !== 1'b1) $display("FAIL reg0_issue_%0d: got %b exp 1", i, iss_ready); else passed++;
        end
        next_cycle();
        wb_valid = 1; wb_wn = 0; wb_d = 32'hFF; #2;
        total++; if (rf_we !== 1'b0) $display("FAIL reg0_wb_we: got %b exp 0", rf_we); else passed++;
        next_cycle(); #2;
        total++; if (err !== 1'b0) $display("FAIL reg0_no_err: got %b exp 0", err); else passed++;
    endtask

    task automatic test_err();
        next_cycle();
        wb_valid = 1; wb_wn = 9; wb_d = 32'h9; #2;
        total++; if (rf_we !== 1'b1 || err !== 1'b0) $display("FAIL err_same_cycle: got we=%b err=%b exp 1/0", rf_we, err); else passed++;
        next_cycle(); #2;
        total++; if (err !== 1'b1) $display("FAIL err_set: got %b exp 1", err); else passed++;
        repeat (3) next_cycle();
        #2;
        total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else passed++;
    endtask

    task automatic test_async_reset();
        issue(5'd5, 1'b1);
        next_cycle();
        iss_valid = 1; iss_rs = 5; #1;
        total++; if (iss_ready !== 1'b0 || lu_cnt !== 2'd1) $display("FAIL arst_pre: got ready=%b cnt=%0d exp 0/1", iss_ready, lu_cnt); else passed++;
        rst_n = 0; #1;
        total++; if (iss_ready !== 1'b1 || lu_cnt !== 2'd0 || err !== 1'b0) $display("FAIL arst_immediate: got ready=%b cnt=%0d err=%b exp 1/0/0", iss_ready, lu_cnt, err); else passed++;
        @(negedge clk);
        rst_n = 1;
        next_cycle();
        iss_valid = 1; iss_rs = 5; iss_wen = 1; iss_wn = 5; #2;
        total++; if (iss_ready !== 1'b1 || rf_we !== 1'b0 || lu_ready !== 1'b0) $display("FAIL arst_after: got ready=%b we=%b lu_ready=%b exp 1/0/0", iss_ready, rf_we, lu_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_arb();
        test_lu_full();
        test_reg0();
        test_err();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
